// File: rtl/cpa_pkg.sv
// Shared types and elaboration helpers for the pipelined carry-propagate adder.
package cpa_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  // Width must split into equal chunks, one per pipeline stage.
  function automatic bit cpa_params_ok(int n, int stages);
    return (stages > 0) && (n > 0) && ((n % stages) == 0);
  endfunction

endpackage

// File: rtl/cpa_stage.sv
// One W-bit chunk of the pipelined adder: chunk add with carry-in, registered
// sum, carry-out, signed-overflow flag and valid, all advancing only on en.
module cpa_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         valid_in,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         valid_out,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  logic [W:0]   full;
  logic         msb_carry;
  logic [W-1:0] sum_d, sum_q;
  logic         carry_d, carry_q;
  logic         ovf_d, ovf_q;
  logic         valid_d, valid_q;

  // NOTE: every variable is assigned on every pass, so no latch can be inferred.
  always_comb begin
    full      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    // Carry into the chunk MSB, recovered from its sum bit (s = a ^ b ^ c).
    msb_carry = full[W-1] ^ a[W-1] ^ b[W-1];
    sum_d     = full[W-1:0];
    carry_d   = full[W];
    ovf_d     = msb_carry ^ full[W];
    valid_d   = valid_in;
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (en) begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign valid_out = valid_q;
  assign sum       = sum_q;
  assign cout      = carry_q;
  assign ovf       = ovf_q;

endmodule

// File: rtl/pipelined_cpa.sv
// Pipelined N-bit adder/subtractor: STAGES chunks with one registered carry hop
// each, operand skew and result deskew, valid/ready flow control.
module pipelined_cpa
  import cpa_pkg::*;
#(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  op_t          op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf
);

  if (!cpa_params_ok(N, STAGES)) begin : g_param_check
    $error("pipelined_cpa: N must be a positive multiple of STAGES");
  end

  localparam int W = N / STAGES;

  logic                     en;
  logic [N-1:0]             bb;
  logic                     c0;
  logic [STAGES-1:0][W-1:0] stg_a, stg_b, stg_sum, out_chunk;
  logic [STAGES-1:0]        stg_vin, stg_cin, stg_valid, stg_carry, stg_ovf;
  logic                     unused_ovf;

  always_comb begin
    en = out_ready | ~out_valid;
    bb = (op == OP_SUB) ? ~b : b;
    c0 = cin ^ (op == OP_SUB);
  end

  assign in_ready   = en;
  assign out_valid  = stg_valid[STAGES-1];
  assign cout       = stg_carry[STAGES-1];
  assign ovf        = stg_ovf[STAGES-1];
  assign s          = out_chunk;
  assign unused_ovf = ^stg_ovf;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int D = STAGES - 1 - k;

    if (k == 0) begin : g_head
      assign stg_a[k]   = a[W-1:0];
      assign stg_b[k]   = bb[W-1:0];
      assign stg_cin[k] = c0;
      assign stg_vin[k] = in_valid;
    end else begin : g_skew
      logic [k-1:0][W-1:0] a_skew_d, a_skew_q, b_skew_d, b_skew_q;

      always_comb begin
        a_skew_d[0] = a[k*W +: W];
        b_skew_d[0] = bb[k*W +: W];
        for (int i = 1; i < k; i++) begin
          a_skew_d[i] = a_skew_q[i-1];
          b_skew_d[i] = b_skew_q[i-1];
        end
      end

      // NOTE: data arrays are reset with the valid bits so post-reset state is fully defined.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          a_skew_q <= '0;
          b_skew_q <= '0;
        end else if (en) begin
          a_skew_q <= a_skew_d;
          b_skew_q <= b_skew_d;
        end
      end

      assign stg_a[k]   = a_skew_q[k-1];
      assign stg_b[k]   = b_skew_q[k-1];
      assign stg_cin[k] = stg_carry[k-1];
      assign stg_vin[k] = stg_valid[k-1];
    end

    cpa_stage #(.W(W)) u_stage (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .valid_in (stg_vin[k]),
      .a        (stg_a[k]),
      .b        (stg_b[k]),
      .cin      (stg_cin[k]),
      .valid_out(stg_valid[k]),
      .sum      (stg_sum[k]),
      .cout     (stg_carry[k]),
      .ovf      (stg_ovf[k])
    );

    if (D == 0) begin : g_no_deskew
      assign out_chunk[k] = stg_sum[k];
    end else begin : g_deskew
      logic [D-1:0][W-1:0] dsk_d, dsk_q;

      always_comb begin
        dsk_d[0] = stg_sum[k];
        for (int i = 1; i < D; i++) dsk_d[i] = dsk_q[i-1];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset)   dsk_q <= '0;
        else if (en) dsk_q <= dsk_d;
      end

      assign out_chunk[k] = dsk_q[D-1];
    end
  end

endmodule

// File: tb/tb_pipelined_cpa.sv
// Self-checking bench: directed N=8/STAGES=2 vectors, back-pressure stream,
// mid-stream reset, and an N=32 latency/accuracy sweep over STAGES 1,2,4,8.
module tb_pipelined_cpa;
  import cpa_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, ovf8;
  logic [7:0] a8, b8, s8;
  op_t        op8;

  pipelined_cpa #(.N(8), .STAGES(2)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .op(op8), .out_valid(out_valid8),
    .out_ready(out_ready8), .s(s8), .cout(cout8), .ovf(ovf8)
  );

  logic        sw_in_valid, sw_cin, sw_out_ready;
  logic [31:0] sw_a, sw_b;
  op_t         sw_op;
  logic        sw_in_ready [4];
  logic        sw_out_valid[4];
  logic        sw_cout     [4];
  logic        sw_ovf      [4];
  logic [31:0] sw_s        [4];

  for (genvar j = 0; j < 4; j++) begin : g_sweep
    pipelined_cpa #(.N(32), .STAGES(1 << j)) u_sw (
      .clk(clk), .reset(reset), .in_valid(sw_in_valid), .in_ready(sw_in_ready[j]),
      .a(sw_a), .b(sw_b), .cin(sw_cin), .op(sw_op), .out_valid(sw_out_valid[j]),
      .out_ready(sw_out_ready), .s(sw_s[j]), .cout(sw_cout[j]), .ovf(sw_ovf[j])
    );
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: returns {ovf, cout, s} with s in the low n bits.
  function automatic logic [33:0] golden(input int n, input logic [31:0] ga, input logic [31:0] gb,
                                         input logic gc, input op_t gop);
    longint unsigned m, hm, av, bv, c0, full, low;
    logic co, cm;
    m    = (64'd1 << n) - 64'd1;
    hm   = (64'd1 << (n - 1)) - 64'd1;
    av   = {32'd0, ga} & m;
    bv   = {32'd0, ((gop == OP_SUB) ? ~gb : gb)} & m;
    c0   = {63'd0, gc ^ (gop == OP_SUB)};
    full = av + bv + c0;
    low  = (av & hm) + (bv & hm) + c0;
    co   = full[n];
    cm   = low[n-1];
    return {cm ^ co, co, full[31:0] & m[31:0]};
  endfunction

  function automatic logic [9:0] exp8(input logic [7:0] ga, input logic [7:0] gb,
                                      input logic gc, input op_t gop);
    logic [33:0] g;
    g = golden(8, {24'd0, ga}, {24'd0, gb}, gc, gop);
    return {g[33], g[32], g[7:0]};
  endfunction

  // One beat through the N=8 DUT with out_ready held high; checks latency and result.
  task automatic directed(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                          input logic tc, input op_t top,
                          input logic [7:0] es, input logic ec, input logic eo);
    int lat;
    @(negedge clk);
    a8 = ta; b8 = tb_; cin8 = tc; op8 = top; in_valid8 = 1'b1;
    #1 check({tag, "_in_ready"}, in_ready8, 1);
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, "_latency"}, lat, 2);
    check({tag, "_s"}, s8, es);
    check({tag, "_cout"}, cout8, ec);
    check({tag, "_ovf"}, ovf8, eo);
    @(posedge clk);
    #1 check({tag, "_drained"}, out_valid8, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  q[$];
    logic [9:0]  held;
    logic [33:0] sw_exp[$];
    logic [33:0] lat_exp;
    int          sent, rcvd, cyc, cnt;
    int          idx[4];
    int          lat[4];
    bit          stall_prev;

    reset = 1'b1;
    in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; op8 = OP_ADD;
    sw_in_valid = 1'b0; sw_out_ready = 1'b1; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_op = OP_ADD;

    #2;
    check("reset_out_valid", out_valid8, 0);
    check("reset_in_ready", in_ready8, 1);
    check("reset_outputs", {ovf8, cout8, s8}, 10'h000);
    @(negedge clk) reset = 1'b0;

    directed("add_wrap",   8'hFF, 8'h01, 1'b0, OP_ADD, 8'h00, 1'b1, 1'b0);
    directed("add_ovf",    8'h7F, 8'h01, 1'b0, OP_ADD, 8'h80, 1'b0, 1'b1);
    directed("add_carry",  8'h0F, 8'h00, 1'b1, OP_ADD, 8'h10, 1'b0, 1'b0);
    directed("sub_neg",    8'h05, 8'h07, 1'b0, OP_SUB, 8'hFE, 1'b0, 1'b0);
    directed("sub_ovf",    8'h80, 8'h01, 1'b0, OP_SUB, 8'h7F, 1'b1, 1'b1);
    directed("sub_borrow", 8'h05, 8'h02, 1'b1, OP_SUB, 8'h02, 1'b1, 1'b0);

    // Back-pressure stream with random valid/ready.
    sent = 0; rcvd = 0; cyc = 0; stall_prev = 1'b0; held = '0;
    while ((sent < 64 || rcvd < 64) && cyc < 3000) begin
      @(negedge clk);
      out_ready8 = ($urandom_range(0, 3) != 0);
      if (sent < 64 && $urandom_range(0, 1) == 1) begin
        in_valid8 = 1'b1;
        a8 = 8'($urandom); b8 = 8'($urandom);
        cin8 = 1'($urandom); op8 = op_t'($urandom_range(0, 1));
      end else begin
        in_valid8 = 1'b0;
      end
      #1;
      if (stall_prev) check("bp_hold", {out_valid8, ovf8, cout8, s8}, {1'b1, held});
      if (out_valid8 && !out_ready8) begin
        check("bp_stall_in_ready", in_ready8, 0);
        held = {ovf8, cout8, s8};
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
      if (out_valid8 && out_ready8) begin
        check("bp_order", q.size() > 0, 1);
        if (q.size() > 0) check("bp_data", {ovf8, cout8, s8}, q.pop_front());
        rcvd++;
      end
      if (in_valid8 && in_ready8) begin
        q.push_back(exp8(a8, b8, cin8, op8));
        sent++;
      end
      cyc++;
    end
    check("bp_received", rcvd, 64);
    check("bp_sent", sent, 64);

    // Reset with two beats in flight.
    @(negedge clk);
    out_ready8 = 1'b1; in_valid8 = 1'b1; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; op8 = OP_ADD;
    @(posedge clk);
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h44;
    @(posedge clk);
    #1 check("rst_pre_beat", {out_valid8, s8}, {1'b1, 8'h33});
    #1 reset = 1'b1;
    a8 = 8'h55; b8 = 8'h01;
    #1;
    check("rst_out_valid", out_valid8, 0);
    check("rst_in_ready", in_ready8, 1);
    check("rst_outputs", {ovf8, cout8, s8}, 10'h000);
    @(negedge clk);
    reset = 1'b0;
    a8 = 8'h40; b8 = 8'h02; cin8 = 1'b0; op8 = OP_ADD; in_valid8 = 1'b1;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    check("rst_no_ghost", out_valid8, 0);
    @(posedge clk);
    #1 check("rst_first_beat", {out_valid8, ovf8, cout8, s8}, {1'b1, 2'b00, 8'h42});
    @(posedge clk);
    #1 check("rst_after_first", out_valid8, 0);

    // STAGES sweep at N=32: latency of one beat, then a random stream.
    @(negedge clk);
    sw_a = $urandom; sw_b = $urandom; sw_cin = 1'($urandom); sw_op = OP_SUB;
    lat_exp = golden(32, sw_a, sw_b, sw_cin, sw_op);
    sw_in_valid = 1'b1;
    for (int j = 0; j < 4; j++) lat[j] = 0;
    @(posedge clk);
    #1 sw_in_valid = 1'b0;
    cnt = 1;
    for (int c = 0; c < 12; c++) begin
      for (int j = 0; j < 4; j++) begin
        if (sw_out_valid[j] && lat[j] == 0) begin
          lat[j] = cnt;
          check($sformatf("sw%0d_lat_data", j), {sw_ovf[j], sw_cout[j], sw_s[j]}, lat_exp);
        end
      end
      @(posedge clk);
      #1 cnt++;
    end
    for (int j = 0; j < 4; j++) check($sformatf("sw%0d_latency", j), lat[j], 1 << j);

    for (int j = 0; j < 4; j++) idx[j] = 0;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      if (sw_exp.size() < 24 && $urandom_range(0, 3) != 0) begin
        sw_a = $urandom; sw_b = $urandom;
        sw_cin = 1'($urandom); sw_op = op_t'($urandom_range(0, 1));
        sw_in_valid = 1'b1;
        sw_exp.push_back(golden(32, sw_a, sw_b, sw_cin, sw_op));
      end else begin
        sw_in_valid = 1'b0;
      end
      #1 check("sw_in_ready", {sw_in_ready[0], sw_in_ready[1], sw_in_ready[2], sw_in_ready[3]}, 4'hF);
      @(posedge clk);
      #1;
      for (int j = 0; j < 4; j++) begin
        if (sw_out_valid[j]) begin
          check($sformatf("sw%0d_order", j), idx[j] < sw_exp.size(), 1);
          if (idx[j] < sw_exp.size())
            check($sformatf("sw%0d_data", j), {sw_ovf[j], sw_cout[j], sw_s[j]}, sw_exp[idx[j]]);
          idx[j]++;
        end
      end
    end
    for (int j = 0; j < 4; j++) check($sformatf("sw%0d_count", j), idx[j], sw_exp.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
